xm_ctrl: RTL

Parametrised XM expansion controller. It succeeds the single-register XCTRL1 handling inside the cart block.
- Implements all five XM control registers (CTRL1–CTRL5) with their lock and sticky rules.
- Generates the banked SALLY/MARIA RAM page address for the $4000–$7FFF windows, with a configurable page count.
- Sits beside cart and drives pokey/ym/hsc enables and the XM RAM chip-select/address.

---
 rtl/xm_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/xm_ctrl.sv
// XM expansion controller: CTRL1-CTRL5 registers with lock/sticky rules and banked XM RAM addressing.
// Optional macro XM_READBACK_EN: combinational register readback on dout/dout_oe.
module xm_ctrl #(
    parameter int          PAGE_BITS = 4,
    parameter logic [11:0] BASE_HI   = 12'h047
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   pclk0,
    input  logic [15:0]            address_in,
    input  logic [7:0]             din,
    input  logic                   rw,
    input  logic                   cart_cs,
    input  logic                   halt_n,
    input  logic                   xm_en,
    output logic [7:0]             dout,
    output logic                   dout_oe,
    output logic                   ram_cs,
    output logic                   ram_we,
    output logic [13+PAGE_BITS-1:0] ram_addr,
    output logic                   pokey_en,
    output logic                   ym_en,
    output logic                   hsc_en,
    output logic                   pia_en,
    output logic                   bios_en,
    output logic                   top_slot,
    output logic                   pal_hsc,
    output logic                   rof_lo,
    output logic                   rof_hi,
    output logic [2:0]             flash_lo,
    output logic [2:0]             flash_hi
);

    localparam logic [3:0] OFF_CTRL1 = 4'h0;
    localparam logic [3:0] OFF_CTRL4 = 4'h1;
    localparam logic [3:0] OFF_CTRL5 = 4'h2;
    localparam logic [3:0] OFF_CTRL2 = 4'h8;
    localparam logic [3:0] OFF_CTRL3 = 4'hC;

    logic [7:0] ctrl1_q, ctrl1_d;
    logic [7:0] ctrl2_q, ctrl2_d;
    logic [7:0] ctrl3_q, ctrl3_d;
    logic [7:0] ctrl4_q, ctrl4_d;
    logic [7:0] ctrl5_q, ctrl5_d;
    logic       pokey_lock_q, pokey_lock_d;
    logic       hsc_sticky_q, hsc_sticky_d;
    logic       pal_hsc_q, pal_hsc_d;

    logic       reg_hit;
    logic       wr_stb;
    logic [3:0] reg_off;
    logic       top_lock;

    assign reg_hit  = xm_en & cart_cs & (address_in[15:4] == BASE_HI);
    assign wr_stb   = reg_hit & ~rw & pclk0;
    assign reg_off  = address_in[3:0];
    assign top_lock = ctrl4_q[7];

    // Lock bits sample the value already stored, so a lock-setting write never blocks itself.
    always_comb begin
        ctrl1_d      = ctrl1_q;
        ctrl2_d      = ctrl2_q;
        ctrl3_d      = ctrl3_q;
        ctrl4_d      = ctrl4_q;
        ctrl5_d      = ctrl5_q;
        pokey_lock_d = pokey_lock_q;
        hsc_sticky_d = hsc_sticky_q;
        pal_hsc_d    = pal_hsc_q;
        if (wr_stb) begin
            case (reg_off)
                OFF_CTRL1: begin
                    ctrl1_d = din;
                    if (top_lock) begin
                        ctrl1_d[2] = ctrl1_q[2];
                    end
                    if (pokey_lock_q) begin
                        ctrl1_d[4] = ctrl1_q[4];
                    end
                    if (din[3]) begin
                        hsc_sticky_d = 1'b1;
                    end
                end
                OFF_CTRL4: begin
                    ctrl4_d = {ctrl4_q[7] | din[7], din[6:0]};
                end
                OFF_CTRL5: begin
                    ctrl5_d      = din;
                    pokey_lock_d = pokey_lock_q | din[3];
                    pal_hsc_d    = pal_hsc_q | din[5];
                end
                OFF_CTRL2: ctrl2_d = din;
                OFF_CTRL3: ctrl3_d = din;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ctrl1_q      <= 8'h00;
            ctrl2_q      <= 8'h00;
            ctrl3_q      <= 8'h00;
            ctrl4_q      <= 8'h00;
            ctrl5_q      <= 8'h00;
            pokey_lock_q <= 1'b0;
            hsc_sticky_q <= 1'b0;
            pal_hsc_q    <= 1'b0;
        end else begin
            ctrl1_q      <= ctrl1_d;
            ctrl2_q      <= ctrl2_d;
            ctrl3_q      <= ctrl3_d;
            ctrl4_q      <= ctrl4_d;
            ctrl5_q      <= ctrl5_d;
            pokey_lock_q <= pokey_lock_d;
            hsc_sticky_q <= hsc_sticky_d;
            pal_hsc_q    <= pal_hsc_d;
        end
    end

    assign rof_lo   = ctrl1_q[0];
    assign rof_hi   = ctrl1_q[1];
    assign top_slot = ctrl1_q[2];
    assign hsc_en   = ctrl1_q[3] | hsc_sticky_q;
    assign pokey_en = ctrl1_q[4];
    assign ym_en    = ctrl1_q[7];
    assign pia_en   = ctrl4_q[0];
    assign flash_lo = ctrl4_q[3:1];
    assign flash_hi = ctrl4_q[6:4];
    assign bios_en  = ctrl5_q[2];
    assign pal_hsc  = pal_hsc_q;

    logic       win0;
    logic       win1;
    logic [7:0] page_src;
    logic [3:0] page_nib;

    assign win0     = (address_in[15:13] == 3'b010) & ctrl1_q[5];
    assign win1     = (address_in[15:13] == 3'b011) & ctrl1_q[6];
    assign ram_cs   = xm_en & cart_cs & (win0 | win1);
    assign ram_we   = ram_cs & ~rw & pclk0 & ~ctrl5_q[1];

    // MARIA DMA (halt_n low) uses its own bank register so CPU and DMA views can differ.
    assign page_src = halt_n ? ctrl2_q : ctrl3_q;
    assign page_nib = win1 ? page_src[7:4] : page_src[3:0];
    assign ram_addr = ram_cs ? {page_nib[PAGE_BITS-1:0], address_in[12:0]} : '0;

`ifdef XM_READBACK_EN
    logic [7:0] rd_data;
    logic       rd_dec;

    always_comb begin
        rd_data = 8'h00;
        rd_dec  = 1'b1;
        case (reg_off)
            OFF_CTRL1: rd_data = ctrl1_q;
            OFF_CTRL4: rd_data = ctrl4_q;
            OFF_CTRL5: rd_data = {ctrl5_q[7:6], pal_hsc_q, hsc_sticky_q, pokey_lock_q, ctrl5_q[2:0]};
            OFF_CTRL2: rd_data = ctrl2_q;
            OFF_CTRL3: rd_data = ctrl3_q;
            default:   rd_dec  = 1'b0;
        endcase
    end

    assign dout_oe = reg_hit & rw & rd_dec;
    assign dout    = dout_oe ? rd_data : 8'h00;
`else
    assign dout_oe = 1'b0;
    assign dout    = 8'h00;
`endif

    // Bits only observable through readback or narrower page widths.
    logic unused_bits;
    assign unused_bits = ^{ctrl5_q[7:6], ctrl5_q[0], page_nib};

endmodule
